// File: rtl/hazard_scoreboard_pkg.sv
// Shared encodings for the hazard scoreboard: operand forwarding selects
// and the hard-wired zero register index.
package hazard_pkg;

    typedef enum logic [1:0] {
        FWD_REG = 2'b00,
        FWD_W   = 2'b01,
        FWD_M   = 2'b10
    } fwd_sel_e;

    typedef enum logic [1:0] {
        BFWD_REG = 2'b00,
        BFWD_E   = 2'b01,
        BFWD_M   = 2'b10,
        BFWD_W   = 2'b11
    } bfwd_sel_e;

    localparam int unsigned ZERO_REG = 0;

endpackage

// File: rtl/hazard_scoreboard_if.sv
// Pipeline-to-hazard-unit signal bundle. The core side drives stage
// information (master); the hazard unit returns stall/flush/forward controls (slave).
interface hazard_scoreboard_if
    import hazard_pkg::*;
#(
    parameter int NREG = 32,
    parameter int AW   = 5
) ();
    logic [AW-1:0]   rs1_d, rs2_d;
    logic            div_d;
    logic [AW-1:0]   rs1_e, rs2_e, rd_e;
    logic            uses_rs2_e;
    logic            regwrite_e, regwrite_m, regwrite_w;
    logic [AW-1:0]   rd_m, rd_w;
    logic            memtoreg_e;
    logic            div_issue_e;
    logic            div_done;
    logic [AW-1:0]   div_rd;
    logic            pc_src_e;
    logic            mem_busy;

    logic            stall_f, stall_d, stall_e;
    logic            flush_d, flush_e;
    fwd_sel_e        forward_ae, forward_be;
    bfwd_sel_e       branch_fwd_a, branch_fwd_b;
    logic [NREG-1:0] pending_mask;
    logic            stall_timeout;

    modport master (
        output rs1_d, rs2_d, div_d, rs1_e, rs2_e, rd_e, uses_rs2_e,
               regwrite_e, regwrite_m, regwrite_w, rd_m, rd_w, memtoreg_e,
               div_issue_e, div_done, div_rd, pc_src_e, mem_busy,
        input  stall_f, stall_d, stall_e, flush_d, flush_e, forward_ae, forward_be,
               branch_fwd_a, branch_fwd_b, pending_mask, stall_timeout
    );

    modport slave (
        input  rs1_d, rs2_d, div_d, rs1_e, rs2_e, rd_e, uses_rs2_e,
               regwrite_e, regwrite_m, regwrite_w, rd_m, rd_w, memtoreg_e,
               div_issue_e, div_done, div_rd, pc_src_e, mem_busy,
        output stall_f, stall_d, stall_e, flush_d, flush_e, forward_ae, forward_be,
               branch_fwd_a, branch_fwd_b, pending_mask, stall_timeout
    );
endinterface

// File: rtl/hazard_scoreboard_load_track_pipe.sv
// Shift register of in-flight load destinations (entry 0 = load now in M)
// with per-entry match against the two decode sources.
module load_track_pipe
    import hazard_pkg::*;
#(
    parameter int AW       = 5,
    parameter int LOAD_LAT = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                adv_i,
    input  logic                ld_vld_i,
    input  logic [AW-1:0]       ld_rd_i,
    input  logic [AW-1:0]       rs1_i,
    input  logic [AW-1:0]       rs2_i,
    output logic [LOAD_LAT-1:0] match1_o,
    output logic [LOAD_LAT-1:0] match2_o,
    output logic                head_vld_o
);

    logic [LOAD_LAT-1:0] vld_q, vld_d;
    logic [AW-1:0]       rd_q [LOAD_LAT];
    logic [AW-1:0]       rd_d [LOAD_LAT];

    always_comb begin
        vld_d    = vld_q;
        rd_d     = rd_q;
        vld_d[0] = ld_vld_i;
        rd_d[0]  = ld_rd_i;
        for (int i = 1; i < LOAD_LAT; i++) begin
            vld_d[i] = vld_q[i-1];
            rd_d[i]  = rd_q[i-1];
        end
    end

    // Only the valid bits need reset; rd is qualified by them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
        end else if (adv_i) begin
            vld_q <= vld_d;
        end
    end

    always_ff @(posedge clk) begin
        if (adv_i) begin
            rd_q <= rd_d;
        end
    end

    always_comb begin
        for (int i = 0; i < LOAD_LAT; i++) begin
            match1_o[i] = vld_q[i] && (rs1_i != AW'(ZERO_REG)) && (rd_q[i] == rs1_i);
            match2_o[i] = vld_q[i] && (rs2_i != AW'(ZERO_REG)) && (rd_q[i] == rs2_i);
        end
    end

    assign head_vld_o = vld_q[0];

endmodule

// File: rtl/hazard_scoreboard.sv
// Scoreboard hazard unit: load-use and divide-pending stalls, branch flush,
// memory back-pressure, ALU/branch forwarding and a sticky stall watchdog.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int NREG          = 32,
    parameter int AW            = 5,
    parameter int LOAD_LAT      = 2,
    parameter int STALL_TIMEOUT = 255,
    parameter int CW            = 8
) (
    input logic                 clk,
    input logic                 rst,
    hazard_scoreboard_if.slave  hz
);

    localparam logic [LOAD_LAT-1:0] EARLY_MASK = LOAD_LAT'((1 << (LOAD_LAT - 1)) - 1);
    localparam logic [CW-1:0]       TIMEOUT    = CW'(STALL_TIMEOUT);
    localparam logic [AW-1:0]       X0         = AW'(ZERO_REG);

    logic [NREG-1:0]     pending_q, pending_d, pending_live;
    logic                busy_q, busy_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                tmo_q, tmo_d;
    logic [LOAD_LAT-1:0] match1, match2;
    logic                m_is_load;
    logic                load_use, div_hazard;

    load_track_pipe #(.AW(AW), .LOAD_LAT(LOAD_LAT)) u_load_track (
        .clk        (clk),
        .rst        (rst),
        .adv_i      (!hz.mem_busy),
        .ld_vld_i   (hz.memtoreg_e && (hz.rd_e != X0)),
        .ld_rd_i    (hz.rd_e),
        .rs1_i      (hz.rs1_d),
        .rs2_i      (hz.rs2_d),
        .match1_o   (match1),
        .match2_o   (match2),
        .head_vld_o (m_is_load)
    );

    function automatic fwd_sel_e alu_sel(input logic src_nz, input logic m_hit, input logic w_hit);
        if (!src_nz)   return FWD_REG;
        else if (m_hit) return FWD_M;
        else if (w_hit) return FWD_W;
        else            return FWD_REG;
    endfunction

    function automatic bfwd_sel_e br_sel(input logic src_nz, input logic e_hit,
                                         input logic m_hit, input logic w_hit);
        if (!src_nz)   return BFWD_REG;
        else if (e_hit) return BFWD_E;
        else if (m_hit) return BFWD_M;
        else if (w_hit) return BFWD_W;
        else            return BFWD_REG;
    endfunction

    // A completing divide releases its consumer in the same cycle.
    always_comb begin
        pending_live = pending_q;
        if (hz.div_done) begin
            pending_live[hz.div_rd] = 1'b0;
        end
    end

    always_comb begin
        load_use = (hz.memtoreg_e && (hz.rd_e != X0) &&
                    ((hz.rd_e == hz.rs1_d) || (hz.rd_e == hz.rs2_d)))
                   || |(match1 & EARLY_MASK) || |(match2 & EARLY_MASK);
        div_hazard = ((hz.rs1_d != X0) && pending_live[hz.rs1_d])
                     || ((hz.rs2_d != X0) && pending_live[hz.rs2_d])
                     || (hz.div_d && busy_q && !hz.div_done);
    end

    always_comb begin
        hz.stall_f = 1'b0;
        hz.stall_d = 1'b0;
        hz.stall_e = 1'b0;
        hz.flush_d = 1'b0;
        hz.flush_e = 1'b0;
        if (hz.mem_busy) begin
            hz.stall_f = 1'b1;
            hz.stall_d = 1'b1;
            hz.stall_e = 1'b1;
        end else if (hz.pc_src_e) begin
            hz.flush_d = 1'b1;
            hz.flush_e = 1'b1;
        end else if (load_use || div_hazard) begin
            hz.stall_f = 1'b1;
            hz.stall_d = 1'b1;
            hz.flush_e = 1'b1;
        end
    end

    always_comb begin
        hz.forward_ae = alu_sel(hz.rs1_e != X0,
                                hz.regwrite_m && (hz.rd_m == hz.rs1_e),
                                hz.regwrite_w && (hz.rd_w == hz.rs1_e));
        hz.forward_be = alu_sel(hz.uses_rs2_e && (hz.rs2_e != X0),
                                hz.regwrite_m && (hz.rd_m == hz.rs2_e),
                                hz.regwrite_w && (hz.rd_w == hz.rs2_e));
        hz.branch_fwd_a = br_sel(hz.rs1_d != X0,
                                 hz.regwrite_e && (hz.rd_e == hz.rs1_d),
                                 hz.regwrite_m && !m_is_load && (hz.rd_m == hz.rs1_d),
                                 hz.regwrite_w && (hz.rd_w == hz.rs1_d));
        hz.branch_fwd_b = br_sel(hz.rs2_d != X0,
                                 hz.regwrite_e && (hz.rd_e == hz.rs2_d),
                                 hz.regwrite_m && !m_is_load && (hz.rd_m == hz.rs2_d),
                                 hz.regwrite_w && (hz.rd_w == hz.rs2_d));
    end

    // Issue is applied after completion so a same-cycle set wins.
    always_comb begin
        pending_d = pending_q;
        busy_d    = busy_q;
        if (hz.div_done) begin
            pending_d[hz.div_rd] = 1'b0;
            busy_d               = 1'b0;
        end
        if (hz.div_issue_e) begin
            busy_d = 1'b1;
            if (hz.rd_e != X0) begin
                pending_d[hz.rd_e] = 1'b1;
            end
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (!hz.mem_busy) begin
            if (hz.stall_d) begin
                cnt_d = (cnt_q < TIMEOUT) ? cnt_q + CW'(1) : cnt_q;
            end else begin
                cnt_d = '0;
            end
        end
        tmo_d = tmo_q || (cnt_d >= TIMEOUT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q <= '0;
            busy_q    <= 1'b0;
            cnt_q     <= '0;
            tmo_q     <= 1'b0;
        end else begin
            pending_q <= pending_d;
            busy_q    <= busy_d;
            cnt_q     <= cnt_d;
            tmo_q     <= tmo_d;
        end
    end

    assign hz.pending_mask  = pending_q;
    assign hz.stall_timeout = tmo_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Randomised and directed bench for hazard_scoreboard against a queue-based
// reference model of in-flight loads, divide ownership and stall run length.
module tb_hazard_scoreboard;
    import hazard_pkg::*;

    localparam int NREG = 32, AW = 5, LOAD_LAT = 2, STALL_TIMEOUT = 255, CW = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    hazard_scoreboard_if #(.NREG(NREG), .AW(AW)) hz ();

    hazard_scoreboard #(.NREG(NREG), .AW(AW), .LOAD_LAT(LOAD_LAT),
                        .STALL_TIMEOUT(STALL_TIMEOUT), .CW(CW)) dut (
        .clk (clk),
        .rst (rst),
        .hz  (hz)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: loads in flight with their age in advancing cycles.
    typedef struct { int rd; int age; } ld_t;
    ld_t         ldq[$];
    bit [NREG-1:0] m_pend;
    bit          m_busy;
    int          m_run;
    bit          m_tmo;

    task automatic model_reset();
        ldq.delete();
        m_pend = '0;
        m_busy = 1'b0;
        m_run  = 0;
        m_tmo  = 1'b0;
    endtask

    function automatic logic [1:0] exp_alu(int s, bit en);
        if (!en || s == 0) return 2'b00;
        if (hz.regwrite_m && int'(hz.rd_m) == s) return 2'b10;
        if (hz.regwrite_w && int'(hz.rd_w) == s) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic [1:0] exp_br(int s);
        bit m_load = 1'b0;
        foreach (ldq[i]) if (ldq[i].age == 0) m_load = 1'b1;
        if (s == 0) return 2'b00;
        if (hz.regwrite_e && int'(hz.rd_e) == s) return 2'b01;
        if (hz.regwrite_m && !m_load && int'(hz.rd_m) == s) return 2'b10;
        if (hz.regwrite_w && int'(hz.rd_w) == s) return 2'b11;
        return 2'b00;
    endfunction

    task automatic idle();
        hz.rs1_d = '0; hz.rs2_d = '0; hz.div_d = 1'b0;
        hz.rs1_e = '0; hz.rs2_e = '0; hz.rd_e = '0; hz.uses_rs2_e = 1'b0;
        hz.regwrite_e = 1'b0; hz.regwrite_m = 1'b0; hz.regwrite_w = 1'b0;
        hz.rd_m = '0; hz.rd_w = '0; hz.memtoreg_e = 1'b0;
        hz.div_issue_e = 1'b0; hz.div_done = 1'b0; hz.div_rd = '0;
        hz.pc_src_e = 1'b0; hz.mem_busy = 1'b0;
    endtask

    // Called at a falling edge with inputs applied; checks, advances model, waits next falling edge.
    task automatic step();
        bit lu, dv, sf, sd, se, fd, fe;
        bit [NREG-1:0] live;
        int srcs[2];
        ld_t nq[$];
        #1;
        live = m_pend;
        if (hz.div_done) live[hz.div_rd] = 1'b0;
        srcs[0] = int'(hz.rs1_d);
        srcs[1] = int'(hz.rs2_d);
        lu = 1'b0;
        dv = 1'b0;
        for (int k = 0; k < 2; k++) begin
            if (srcs[k] != 0) begin
                if (hz.memtoreg_e && int'(hz.rd_e) == srcs[k]) lu = 1'b1;
                foreach (ldq[i]) if (ldq[i].age < LOAD_LAT - 1 && ldq[i].rd == srcs[k]) lu = 1'b1;
                if (live[srcs[k]]) dv = 1'b1;
            end
        end
        if (hz.div_d && m_busy && !hz.div_done) dv = 1'b1;
        {sf, sd, se, fd, fe} = '0;
        if (hz.mem_busy) {sf, sd, se} = 3'b111;
        else if (hz.pc_src_e) {fd, fe} = 2'b11;
        else if (lu || dv) {sf, sd, fe} = 3'b111;

        chk("stall_f", hz.stall_f, sf);
        chk("stall_d", hz.stall_d, sd);
        chk("stall_e", hz.stall_e, se);
        chk("flush_d", hz.flush_d, fd);
        chk("flush_e", hz.flush_e, fe);
        chk("forward_ae", hz.forward_ae, exp_alu(int'(hz.rs1_e), 1'b1));
        chk("forward_be", hz.forward_be, exp_alu(int'(hz.rs2_e), hz.uses_rs2_e));
        chk("branch_fwd_a", hz.branch_fwd_a, exp_br(int'(hz.rs1_d)));
        chk("branch_fwd_b", hz.branch_fwd_b, exp_br(int'(hz.rs2_d)));
        chk("pending_mask", hz.pending_mask, m_pend);
        chk("stall_timeout", hz.stall_timeout, m_tmo);

        if (!hz.mem_busy) begin
            foreach (ldq[i]) if (ldq[i].age + 1 < LOAD_LAT) nq.push_back('{ldq[i].rd, ldq[i].age + 1});
            if (hz.memtoreg_e && hz.rd_e != 0) nq.push_back('{int'(hz.rd_e), 0});
            ldq = nq;
        end
        if (hz.div_done) begin
            m_pend[hz.div_rd] = 1'b0;
            m_busy = 1'b0;
        end
        if (hz.div_issue_e) begin
            m_busy = 1'b1;
            if (hz.rd_e != 0) m_pend[hz.rd_e] = 1'b1;
        end
        if (!hz.mem_busy) begin
            if (sd) begin
                if (m_run < STALL_TIMEOUT) m_run++;
            end else begin
                m_run = 0;
            end
            if (m_run >= STALL_TIMEOUT) m_tmo = 1'b1;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        #2 rst = 1'b1;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        idle();
    endtask

    initial begin
        idle();
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_pending", hz.pending_mask, 0);
        chk("rst_timeout", hz.stall_timeout, 0);
        chk("rst_stall_d", hz.stall_d, 0);
        chk("rst_flush_e", hz.flush_e, 0);
        @(negedge clk);
        rst = 1'b0;

        // Load-use with LOAD_LAT=2: two bubbles, then W forwarding for the branch.
        hz.regwrite_e = 1'b1; hz.memtoreg_e = 1'b1; hz.rd_e = 5; hz.rs1_d = 5;
        #1 chk("lu_c1_stall", hz.stall_d, 1);
        chk("lu_c1_flush", hz.flush_e, 1);
        step();
        idle(); hz.rs1_d = 5;
        #1 chk("lu_c2_stall", hz.stall_d, 1);
        step();
        idle(); hz.rs1_d = 5; hz.regwrite_w = 1'b1; hz.rd_w = 5;
        #1 chk("lu_c3_stall", hz.stall_d, 0);
        chk("lu_c3_bfwd", hz.branch_fwd_a, 2'b11);
        step();

        // Divide scoreboard.
        do_reset();
        hz.div_issue_e = 1'b1; hz.rd_e = 7;
        step();
        idle(); hz.rs2_d = 7;
        #1 chk("div_mask7", hz.pending_mask[7], 1);
        for (int i = 0; i < 10; i++) begin
            #1 chk("div_stall", hz.stall_d, 1);
            step();
        end
        hz.div_done = 1'b1; hz.div_rd = 7;
        #1 chk("div_drop", hz.stall_d, 0);
        step();
        idle(); hz.rs2_d = 7;
        #1 chk("div_mask_clr", hz.pending_mask, 0);
        step();
        idle(); hz.div_issue_e = 1'b1; hz.rd_e = 8;
        step();
        idle(); hz.div_d = 1'b1;
        #1 chk("div_busy_stall", hz.stall_d, 1);
        step();

        // Flush and back-pressure priority.
        do_reset();
        hz.regwrite_e = 1'b1; hz.memtoreg_e = 1'b1; hz.rd_e = 5; hz.rs1_d = 5; hz.pc_src_e = 1'b1;
        #1 chk("pc_flush_d", hz.flush_d, 1);
        chk("pc_flush_e", hz.flush_e, 1);
        chk("pc_stall_d", hz.stall_d, 0);
        hz.mem_busy = 1'b1;
        #1 chk("mb_stall_e", hz.stall_e, 1);
        chk("mb_flush_d", hz.flush_d, 0);
        step();

        // ALU forwarding.
        idle(); hz.regwrite_m = 1'b1; hz.regwrite_w = 1'b1; hz.rd_m = 3; hz.rd_w = 3;
        hz.rs1_e = 3; hz.rs2_e = 3; hz.uses_rs2_e = 1'b0;
        #1 chk("fwd_ae_m", hz.forward_ae, 2'b10);
        chk("fwd_be_nouse", hz.forward_be, 2'b00);
        step();
        idle(); hz.regwrite_m = 1'b1; hz.rd_m = 0; hz.rs1_e = 0;
        #1 chk("fwd_ae_x0", hz.forward_ae, 2'b00);
        step();

        // Watchdog.
        do_reset();
        hz.div_issue_e = 1'b1; hz.rd_e = 7;
        step();
        idle(); hz.rs2_d = 7;
        repeat (STALL_TIMEOUT - 1) step();
        #1 chk("wd_before", hz.stall_timeout, 0);
        step();
        #1 chk("wd_hit", hz.stall_timeout, 1);
        hz.div_done = 1'b1; hz.div_rd = 7;
        step();
        idle();
        #1 chk("wd_sticky", hz.stall_timeout, 1);
        step();
        do_reset();
        #1 chk("wd_rst", hz.stall_timeout, 0);

        // Asynchronous reset in the middle of a divide.
        hz.div_issue_e = 1'b1; hz.rd_e = 9;
        step();
        idle();
        #1 chk("ar_mask9", hz.pending_mask[9], 1);
        #1 rst = 1'b1;
        model_reset();
        #1 chk("ar_mask_clr", hz.pending_mask, 0);
        hz.div_d = 1'b1;
        #1 chk("ar_no_busy", hz.stall_d, 0);
        @(negedge clk);
        rst = 1'b0;
        step();
        idle(); hz.div_done = 1'b1; hz.div_rd = 9;
        step();
        idle(); hz.div_d = 1'b1;
        #1 chk("ar_after_done", hz.pending_mask, 0);
        step();

        // Randomised traffic.
        do_reset();
        for (int c = 0; c < 2000; c++) begin
            hz.rs1_d       = AW'($urandom_range(0, 7));
            hz.rs2_d       = AW'($urandom_range(0, 7));
            hz.div_d       = ($urandom_range(0, 3) == 0);
            hz.rs1_e       = AW'($urandom_range(0, 7));
            hz.rs2_e       = AW'($urandom_range(0, 7));
            hz.rd_e        = AW'($urandom_range(0, 7));
            hz.uses_rs2_e  = 1'($urandom_range(0, 1));
            hz.memtoreg_e  = ($urandom_range(0, 2) == 0);
            hz.regwrite_e  = hz.memtoreg_e | 1'($urandom_range(0, 1));
            hz.regwrite_m  = 1'($urandom_range(0, 1));
            hz.regwrite_w  = 1'($urandom_range(0, 1));
            hz.rd_m        = AW'($urandom_range(0, 7));
            hz.rd_w        = AW'($urandom_range(0, 7));
            hz.div_issue_e = ($urandom_range(0, 9) == 0);
            hz.div_done    = ($urandom_range(0, 5) == 0);
            hz.div_rd      = AW'($urandom_range(0, 7));
            hz.pc_src_e    = ($urandom_range(0, 7) == 0);
            hz.mem_busy    = ($urandom_range(0, 7) == 0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised next-generation hazard unit for the pipelined RV core.
- Replaces the decode-time combinational hazard check with a scoreboard. It tracks in-flight multi-cycle writers: a load shift pipeline of configurable depth and a single non-pipelined divider.
- Generates stall, flush and forwarding selects for the F/D/E stages, handles taken-branch flush and memory back-pressure, and flags a stall watchdog timeout.

Parameters:
- NREG, 32, architectural register count (x0 hard-wired zero).
- AW, 5, register index width, clog2(NREG).
- LOAD_LAT, 2, cycles from load leaving E until its data is forwardable from W (range 1..4).
- STALL_TIMEOUT, 255, consecutive stall_d cycles before stall_timeout sets.
- CW, 8, watchdog counter width; must hold STALL_TIMEOUT.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous active-high reset
- rs1_d, rs2_d  in  AW  decode sources
- div_d  in  1  decode instruction is a divide
- rs1_e, rs2_e, rd_e  in  AW  execute sources and destination
- uses_rs2_e  in  1  E instruction reads rs2 (R/S/B-type)
- regwrite_e, regwrite_m, regwrite_w  in  1  stage writes rd
- rd_m, rd_w  in  AW  destinations in M and W
- memtoreg_e  in  1  E instruction is a load
- div_issue_e  in  1  divide leaves E into the divider this cycle
- div_done  in  1  divider result written back this cycle
- div_rd  in  AW  destination of the completing divide
- pc_src_e  in  1  taken branch/jump resolved in E
- mem_busy  in  1  data memory not ready
- stall_f, stall_d, stall_e  out  1  hold stage registers
- flush_d, flush_e  out  1  insert bubble into D/E
- forward_ae, forward_be  out  2  ALU operand select: 00 reg, 10 M, 01 W
- branch_fwd_a, branch_fwd_b  out  2  decode comparator select: 00 reg, 01 E, 10 M, 11 W
- pending_mask  out  NREG  registers with an outstanding divide write
- stall_timeout  out  1  sticky watchdog flag

Behaviour:
- Reset (async, rst=1): load pipeline valid bits, div_busy, pending_mask, watchdog counter and stall_timeout all cleared. With pending state cleared, all stall/flush outputs are 0 unless driven by current inputs. Reset mid-operation discards all in-flight tracking.
- Load pipeline:
  - LOAD_LAT entries of {valid, rd}. Entry 0 loads {memtoreg_e && rd_e!=0, rd_e} when E advances.
  - Entries shift each cycle unless mem_busy. The last entry drops out.
- Load-use stall: D source equals rd_e of a load in E, or rd of any valid entry with index < LOAD_LAT-1 -> stall_f=stall_d=1, flush_e=1.
  - LOAD_LAT=1 gives the classic single-bubble case; LOAD_LAT=2 adds the second bubble for branch operands.
- Divider:
  - div_issue_e with rd_e!=0 sets pending_mask[rd_e]; div_busy is set on every div_issue_e.
  - div_done clears pending_mask[div_rd] and div_busy.
  - Set and clear of the same bit in one cycle: set wins.
  - D source with its pending bit set, or div_d while div_busy -> stall_f=stall_d=1, flush_e=1.
- mem_busy: stall_f=stall_d=stall_e=1, no flush. The load pipeline and watchdog hold.
- Priority (highest first): mem_busy, then pc_src_e, then scoreboard/load-use stalls.
  - pc_src_e (when not mem_busy): flush_d=flush_e=1, stall_d=stall_f=0, because the D instruction is squashed and its hazards are ignored.
- Forwarding:
  - A source of x0 never forwards.
  - ALU operands: M has priority over W. forward_be=00 when !uses_rs2_e.
  - Branch operands: E, then M (only when not a load still in M), then W.
- Watchdog:
  - Counter increments while stall_d=1 and clears when stall_d=0; it saturates.
  - When the counter reaches STALL_TIMEOUT, stall_timeout goes to 1 and stays 1 until rst.
- Latency: stall, flush and forward outputs are combinational from inputs plus registered state. State updates on the rising clk edge.

Decomposition:
- Shared package hazard_pkg holds:
  - forward select encodings (FWD_REG, FWD_M, FWD_W) and branch encodings (BFWD_REG, BFWD_E, BFWD_M, BFWD_W);
  - the ZERO_REG constant.
- One natural sub-module, load_track_pipe, holds the LOAD_LAT-deep valid/rd shift register and the per-entry match vector.

Test Plan:
- LOAD_LAT=2: lw x5 in E, rs1_d=5 -> 1 cycle stall_d/flush_e. Next cycle, entry0 rd=5 and rs1_d=5 -> second stall. Third cycle branch_fwd_a=11, no stall.
- div_issue_e rd_e=7 -> pending_mask[7]=1. rs2_d=7 stalls for 10 cycles. div_done div_rd=7 -> mask clear and stall drops the same cycle. div_d while busy also stalls.
- pc_src_e=1 together with a load-use match -> flush_d=flush_e=1, stall_d=0. With mem_busy=1 as well -> all stalls=1, no flushes.
- rd_m=rd_w=3 with regwrite_m/w, rs1_e=3 -> forward_ae=10. uses_rs2_e=0 with rs2_e=3 -> forward_be=00. rs1_e=0 with rd_m=0 -> 00.
- Hold the div stall for 255 cycles (STALL_TIMEOUT=255) -> stall_timeout=1 on cycle 255 and still 1 after the stall ends. rst -> 0.
- Assert rst mid-divide with pending_mask[9]=1 -> mask=0 and div_busy=0 asynchronously. A later div_done does not underflow or set any bit.
